// File: rtl/even_parity_serial_tx.sv
// rtl/even_parity_serial_tx.sv - serial frame transmitter with supplied-parity check
//
// Accepts a data word plus its even-parity bit and shifts out a frame
// LSB-first: start(0), DATA_W data bits, parity, stop(1). Each serial bit is
// held for CLKS_PER_BIT clocks. The supplied parity is compared against the
// data at accept time and a mismatch is flagged, but the frame is still sent
// with the supplied parity bit.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; aborts any frame in flight
//   data_in     word to transmit
//   parity_in   even parity bit from the upstream generator
//   in_valid    data_in/parity_in valid
//   in_ready    combinational: block is idle and not in reset
//   tx_out      registered serial line, idles high
//   busy        registered, high while a frame is in progress
//   frame_done  registered one-cycle pulse in the final stop-bit cycle
//   par_err     registered one-cycle pulse the cycle after a mismatched accept

module even_parity_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic              par_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_n;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_n;
    logic              par_q;
    logic              par_q_n;

    logic              tx_n;
    logic              busy_n;
    logic              done_n;
    logic              perr_n;

    logic              accept;
    logic              bit_end;

    assign in_ready = (state == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign bit_end  = (cnt == CNT_LAST);

    // Next-state logic. The registered outputs are computed from the next
    // state so that they line up with the state they describe.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_q_n = par_q;
        perr_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_START;
                    cnt_n   = '0;
                    idx_n   = '0;
                    shreg_n = data_in;
                    par_q_n = parity_in;
                    // Even parity: parity bit XOR all data bits must be 0.
                    perr_n  = parity_in ^ (^data_in);
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    if (idx == IDX_LAST) begin
                        state_n = S_PARITY;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_q_n;
            default:  tx_n = 1'b1;
        endcase

        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_STOP) && (cnt_n == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            par_q      <= par_q_n;
            tx_out     <= tx_n;
            busy       <= busy_n;
            frame_done <= done_n;
            par_err    <= perr_n;
        end
    end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// tb/tb_even_parity_serial_tx.sv - scoreboard bench for even_parity_serial_tx

module tb_even_parity_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int FL  = (DW + 3) * CPB;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          parity_in;
    logic          in_valid;
    logic          in_ready;
    logic          tx_out;
    logic          busy;
    logic          frame_done;
    logic          par_err;

    even_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .parity_in (parity_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_out    (tx_out),
        .busy      (busy),
        .frame_done(frame_done),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          p;
        logic          e;
    } exp_t;

    exp_t    q[$];
    int      n_checks = 0;
    int      n_fail = 0;
    int      frames_sent = 0;
    int      frames_seen = 0;
    longint  prev_acc_t = 0;
    longint  last_acc_t = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: bit i of the frame, each held CPB samples.
    function automatic logic [FL-1:0] exp_wave(input logic [DW-1:0] d, input logic p);
        logic [FL-1:0] w;
        for (int k = 0; k < FL; k++) begin
            int i;
            i = k / CPB;
            if (i == 0)       w[k] = 1'b0;
            else if (i <= DW) w[k] = d[i-1];
            else if (i == DW + 1) w[k] = p;
            else              w[k] = 1'b1;
        end
        return w;
    endfunction

    // Start at #1 after a posedge with the DUT idle; returns #1 after the
    // edge that ends the frame's last stop-bit cycle.
    // mode 0: in_valid low during frame, 1: held high, 2: random junk toggling.
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input int mode);
        exp_t e;
        data_in   = d;
        parity_in = p;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("ready_at_accept", in_ready, 1);
        @(posedge clk);
        prev_acc_t = last_acc_t;
        last_acc_t = $time;
        e.d = d;
        e.p = p;
        e.e = (($countones(d) % 2) != 0) != p;
        q.push_back(e);
        frames_sent++;
        #1;
        for (int c = 1; c <= FL; c++) begin
            if (mode == 0) begin
                in_valid = 1'b0;
            end else if (mode == 2) begin
                in_valid  = 1'($urandom % 2);
                data_in   = DW'($urandom);
                parity_in = 1'($urandom);
            end
            @(negedge clk);
            if (c == 10) chk("ready_low_busy", in_ready, 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: captures each frame once busy rises and compares against the
    // head of the expected queue.
    logic [FL-1:0] wave, pev, fdv;
    logic          aborted;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && rst === 1'b0) begin
                aborted = 1'b0;
                for (int s = 0; s < FL; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    wave[s] = tx_out;
                    pev[s]  = par_err;
                    fdv[s]  = frame_done;
                end
                chk("frame_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    frames_seen++;
                    if (!aborted) begin
                        chk("tx_wave", wave, exp_wave(e.d, e.p));
                        chk("par_err_pulse", pev, {{(FL-1){1'b0}}, e.e});
                        chk("frame_done_pulse", fdv, {1'b1, {(FL-1){1'b0}}});
                        @(negedge clk);
                        chk("busy_after_frame", busy, 0);
                        chk("tx_idle_after_frame", tx_out, 1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic          p;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        parity_in = 1'b0;

        // Reset for 3 cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_perr", par_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_tx", tx_out, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Directed frames.
        send_frame(8'hA6, 1'b0, 0);
        idle(2);
        send_frame(8'h0E, 1'b0, 0);
        idle(1);
        send_frame(8'h01, 1'b1, 1);
        send_frame(8'h00, 1'b0, 1);
        chk("b2b_accept_spacing", 64'((last_acc_t - prev_acc_t) / 10), FL + 1);
        idle(1);
        send_frame(8'h5A, 1'b0, 2);
        idle(2);

        // Reset at cycle 20 of a 0xFF frame.
        data_in   = 8'hFF;
        parity_in = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        begin
            exp_t e;
            e.d = 8'hFF;
            e.p = 1'b0;
            e.e = 1'b0;
            q.push_back(e);
            frames_sent++;
        end
        #1;
        in_valid = 1'b0;
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx", tx_out, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send_frame(8'h01, 1'b1, 0);
        idle(1);

        // Randomized frames.
        for (int n = 0; n < 12; n++) begin
            d = DW'($urandom);
            p = 1'(($countones(d) % 2) != 0);
            if ($urandom % 4 == 0) p = ~p;
            send_frame(d, p, int'($urandom % 3));
            idle(int'($urandom % 3));
        end

        idle(3);
        chk("queue_drained", q.size(), 0);
        chk("frames_seen", frames_seen, frames_sent);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
